// File: rtl/disp_pkg.sv
// Shared types and helpers for the BCD scan display block.
package disp_pkg;

  localparam int unsigned BCD_W = 4;

  // All-ones anode pattern; slice to the digit count at the use site.
  localparam logic [31:0] AN_OFF = '1;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } conv_state_e;

  // Double-dabble correction: a digit of 5 or more gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle.
module bin2bcd_seq import disp_pkg::*; #(
  parameter int unsigned BIN_W  = 9,
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_i,
  input  logic [BIN_W-1:0]          bin_in_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [DIGITS*BCD_W-1:0]   bcd_vec_o,
  output logic                      ovf_o
);

  localparam int unsigned DW = DIGITS * BCD_W;
  localparam int unsigned CW = $clog2(BIN_W + 1);

  conv_state_e       state_q, state_d;
  logic [BIN_W-1:0]  shift_q, shift_d;
  logic [DW-1:0]     work_q, work_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sticky_q, sticky_d;
  logic              ovf_q, ovf_d;
  logic [DW-1:0]     adj;
  logic              carry;

  // Per-digit +3 correction of the work register.
  always_comb begin
    adj = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      adj[i*BCD_W +: BCD_W] = add3(work_q[i*BCD_W +: BCD_W]);
    end
  end

  // Next-state and datapath for IDLE/SHIFT/COMMIT.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    carry    = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_i) begin
          shift_d  = bin_in_i;
          work_d   = '0;
          sticky_d = 1'b0;
          cnt_d    = CW'(BIN_W);
          state_d  = StShift;
        end
      end
      StShift: begin
        busy_o = 1'b1;
        // A bit leaving the top digit means the value needs more digits.
        {carry, work_d, shift_d} = {adj, shift_q, 1'b0};
        if (carry) sticky_d = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = StCommit;
      end
      StCommit: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        ovf_d   = sticky_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Converter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bcd_vec_o = work_q;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/bcd_scan_display.sv
// Binary to multiplexed BCD display driver with leading-zero blanking.
module bcd_scan_display import disp_pkg::*; #(
  parameter int unsigned BIN_W       = 9,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BIN_W-1:0]  bin_in_i,
  input  logic              load_i,
  output logic              busy_o,
  output logic [BCD_W-1:0]  bcd_o,
  output logic [DIGITS-1:0] an_o,
  output logic              ovf_o
);

  localparam int unsigned DW = DIGITS * BCD_W;
  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = $clog2(DIGITS);

  logic              conv_done;
  logic [DW-1:0]     conv_vec;
  logic [DW-1:0]     disp_q;
  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [BCD_W-1:0]  digit;
  logic              upper_zero;
  logic              blank;

  bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load_i),
    .bin_in_i  (bin_in_i),
    .busy_o    (busy_o),
    .done_o    (conv_done),
    .bcd_vec_o (conv_vec),
    .ovf_o     (ovf_o)
  );

  // Display register only takes the finished result, never partial work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) disp_q <= '0;
    else if (conv_done) disp_q <= conv_vec;
  end

  // Prescaler and digit index stepping.
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PW'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Digit select and blanking: a slot is blank if it and all above are zero.
  always_comb begin
    digit      = '0;
    upper_zero = 1'b1;
    for (int j = 0; j < int'(DIGITS); j++) begin
      if (idx_q == IW'(j)) digit = disp_q[j*BCD_W +: BCD_W];
      if (IW'(j) >= idx_q && disp_q[j*BCD_W +: BCD_W] != '0) upper_zero = 1'b0;
    end
    blank = (BLANK_LZ != 0) && upper_zero && (idx_q != '0);
    bcd_d = blank ? '0 : digit;
    an_d  = blank ? AN_OFF[DIGITS-1:0] : ~(DIGITS'(1) << idx_q);
  end

  // Scanner state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      bcd_q   <= '0;
      an_q    <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      bcd_q   <= bcd_d;
      an_q    <= an_d;
    end
  end

  assign bcd_o = bcd_q;
  assign an_o  = an_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: four parameter variants share one stimulus stream.
module tb_bcd_scan_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [8:0] bin_in = '0;
  logic       load = 1'b0;

  // a: 4 digits, div 4, blanking; b: no blanking; c: 2 digits; d: div 1, no blanking
  logic       busy_a, busy_b, busy_c, busy_d;
  logic       ovf_a, ovf_b, ovf_c, ovf_d;
  logic [3:0] bcd_a, bcd_b, bcd_c, bcd_d;
  logic [3:0] an_a, an_b, an_d;
  logic [1:0] an_c;

  always #5 clk = ~clk;

  bcd_scan_display #(.BIN_W(9), .DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bin_in_i(bin_in), .load_i(load),
    .busy_o(busy_a), .bcd_o(bcd_a), .an_o(an_a), .ovf_o(ovf_a));
  bcd_scan_display #(.BIN_W(9), .DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(0)) u_b (
    .clk(clk), .rst_n(rst_n), .bin_in_i(bin_in), .load_i(load),
    .busy_o(busy_b), .bcd_o(bcd_b), .an_o(an_b), .ovf_o(ovf_b));
  bcd_scan_display #(.BIN_W(9), .DIGITS(2), .REFRESH_DIV(4), .BLANK_LZ(1)) u_c (
    .clk(clk), .rst_n(rst_n), .bin_in_i(bin_in), .load_i(load),
    .busy_o(busy_c), .bcd_o(bcd_c), .an_o(an_c), .ovf_o(ovf_c));
  bcd_scan_display #(.BIN_W(9), .DIGITS(4), .REFRESH_DIV(1), .BLANK_LZ(0)) u_d (
    .clk(clk), .rst_n(rst_n), .bin_in_i(bin_in), .load_i(load),
    .busy_o(busy_d), .bcd_o(bcd_d), .an_o(an_d), .ovf_o(ovf_d));

  typedef struct {
    logic [8:0]  bin;
    logic [3:0]  mask_a;  // slots visible on the blanking 4-digit variant
    logic [15:0] dig;     // expected 4-digit BCD
    logic [1:0]  mask_c;
    logic [7:0]  dig_c;   // expected low two digits
    logic        ovf_c;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  logic       seen [4][4];
  logic [3:0] val [4][4];
  int         odd [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [3:0] an);
    case (an)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      4'b1111: return -1;
      default: return -2;
    endcase
  endfunction

  // Record what one variant drives this cycle; blank slots must carry bcd 0.
  task automatic note(input int u, input logic [3:0] an, input logic [3:0] bcd);
    int k;
    k = idx_of(an);
    if (k >= 0) begin
      seen[u][k] = 1'b1;
      val[u][k]  = bcd;
    end else if (k == -2 || bcd !== 4'd0) begin
      odd[u]++;
    end
  endtask

  task automatic scan(input int ncyc);
    for (int u = 0; u < 4; u++) begin
      odd[u] = 0;
      for (int k = 0; k < 4; k++) begin
        seen[u][k] = 1'b0;
        val[u][k]  = 4'd0;
      end
    end
    repeat (2) @(posedge clk);
    repeat (ncyc) begin
      @(negedge clk);
      note(0, an_a, bcd_a);
      note(1, an_b, bcd_b);
      note(2, {2'b11, an_c}, bcd_c);
      note(3, an_d, bcd_d);
    end
  endtask

  task automatic check_slots(input string tag, input int u, input logic [3:0] mask,
                             input logic [15:0] dig);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s u%0d slot%0d shown", tag, u, k), 32'(seen[u][k]), 32'(mask[k]));
      if (mask[k]) chk($sformatf("%s u%0d slot%0d digit", tag, u, k), 32'(val[u][k]),
                       32'(dig[k*4 +: 4]));
    end
    chk($sformatf("%s u%0d stray an/bcd", tag, u), odd[u], 0);
  endtask

  // Pulse load for one edge and count the cycles busy stays high afterwards.
  task automatic load_val(input logic [8:0] v, output int n);
    @(negedge clk);
    bin_in = v;
    load   = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    n    = 0;
    while (busy_a === 1'b1 && n < 30) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  vec_t vecs [8];

  initial begin
    int n;
    logic [3:0] e;

    vecs[0] = '{9'd347, 4'b0111, 16'h0347, 2'b11, 8'h47, 1'b1};
    vecs[1] = '{9'd5,   4'b0001, 16'h0005, 2'b01, 8'h05, 1'b0};
    vecs[2] = '{9'd0,   4'b0001, 16'h0000, 2'b01, 8'h00, 1'b0};
    vecs[3] = '{9'd511, 4'b0111, 16'h0511, 2'b11, 8'h11, 1'b1};
    vecs[4] = '{9'd42,  4'b0011, 16'h0042, 2'b11, 8'h42, 1'b0};
    vecs[5] = '{9'd99,  4'b0011, 16'h0099, 2'b11, 8'h99, 1'b0};
    vecs[6] = '{9'd100, 4'b0111, 16'h0100, 2'b01, 8'h00, 1'b1};
    vecs[7] = '{9'd256, 4'b0111, 16'h0256, 2'b11, 8'h56, 1'b1};

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("reset an_a", an_a, 4'b1110);
    chk("reset bcd_a", bcd_a, 4'd0);
    chk("reset busy_a", busy_a, 1'b0);
    chk("reset ovf_c", ovf_c, 1'b0);
    chk("reset an_c", an_c, 2'b10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Index stepping after reset with an all-zero display
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      e = (((k - 1) / 4) % 4 == 0) ? 4'b1110 : 4'b1111;
      chk($sformatf("step%0d an_a", k), an_a, e);
      e = ~(4'b0001 << (((k - 1) / 4) % 4));
      chk($sformatf("step%0d an_b", k), an_b, e);
      chk($sformatf("step%0d bcd_b", k), bcd_b, 4'd0);
      e = ~(4'b0001 << ((k - 1) % 4));
      chk($sformatf("step%0d an_d", k), an_d, e);
    end

    // Conversion vectors
    for (int i = 0; i < 8; i++) begin
      load_val(vecs[i].bin, n);
      chk($sformatf("v%0d busy cycles", i), n, 10);
      chk($sformatf("v%0d ovf_a", i), ovf_a, 1'b0);
      chk($sformatf("v%0d ovf_c", i), ovf_c, vecs[i].ovf_c);
      scan(40);
      check_slots($sformatf("v%0d", i), 0, vecs[i].mask_a, vecs[i].dig);
      check_slots($sformatf("v%0d", i), 1, 4'b1111, vecs[i].dig);
      check_slots($sformatf("v%0d", i), 2, {2'b00, vecs[i].mask_c}, {8'h00, vecs[i].dig_c});
      check_slots($sformatf("v%0d", i), 3, 4'b1111, vecs[i].dig);
    end

    // Reset in the middle of scanning a non-zero display
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midscan an_a", an_a, 4'b1110);
    chk("midscan bcd_a", bcd_a, 4'd0);
    chk("midscan busy_a", busy_a, 1'b0);
    chk("midscan ovf_c", ovf_c, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load while busy is ignored
    @(negedge clk);
    bin_in = 9'd347;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    bin_in = 9'd5;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ignore busy settles", busy_a, 1'b0);
    scan(40);
    check_slots("ignore", 0, 4'b0111, 16'h0347);
    chk("ignore no restart", busy_a, 1'b0);

    // Reset during SHIFT aborts and clears the display
    @(negedge clk);
    bin_in = 9'd511;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy_a", busy_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    scan(40);
    check_slots("abort", 0, 4'b0001, 16'h0000);
    check_slots("abort", 1, 4'b1111, 16'h0000);
    chk("abort stays idle", busy_a, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
